ddr4_mc_act_faw: RTL and testbench



---
 rtl/ddr4_mc_act_faw_if.sv | 27 ++
 rtl/ddr4_mc_act_faw.sv | 118 +++++++++++
 tb/tb_ddr4_mc_act_faw.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ddr4_mc_act_faw_if.sv
// Activate strobe in and activate qualifiers out for ddr4_mc_act_faw.
// master = arbiter/group FSM side, slave = the tracker.
interface ddr4_mc_act_faw_if #(
    parameter int RANK_SLAB = 4
);
    logic [RANK_SLAB-1:0] act_rank_update;
    logic [RANK_SLAB-1:0] faw_ok;
    logic                 rrd_ok;
    logic                 act_viol;
    logic [15:0]          faw_stall_cnt;

    modport master (
        output act_rank_update,
        input  faw_ok,
        input  rrd_ok,
        input  act_viol,
        input  faw_stall_cnt
    );

    modport slave (
        input  act_rank_update,
        output faw_ok,
        output rrd_ok,
        output act_viol,
        output faw_stall_cnt
    );
endinterface

// File: rtl/ddr4_mc_act_faw.sv
// Activate-window tracker. It enforces two limits:
//   - per-rank tFAW, using four down-counting window slots per rank;
//   - global tRRD, using one spacing down-counter.
// Optional stall statistics are enabled by defining DDR4_MC_ACT_FAW_STATS_EN.
// Without that macro, faw_stall_cnt is tied to zero.
module ddr4_mc_act_faw #(
    parameter int RANK_SLAB = 4,
    parameter int TFAW      = 16,
    parameter int TRRD      = 4,
    parameter int CNTW      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ddr4_mc_act_faw_if.slave       bus
);
    localparam logic [CNTW-1:0] FAW_LD = CNTW'(TFAW - 1);
    localparam logic [CNTW-1:0] RRD_LD = CNTW'(TRRD - 1);

    logic [CNTW-1:0]      slot_q   [RANK_SLAB][4];
    logic [3:0]           busy     [RANK_SLAB];
    logic [3:0]           load_sel [RANK_SLAB];
    logic [RANK_SLAB-1:0] faw_ok_c;
    logic [RANK_SLAB-1:0] act;
    logic [CNTW-1:0]      rrd_q;
    logic                 rrd_ok_c;
    logic                 multi_hot;
    logic                 viol_now;
    logic                 viol_q;

    assign act = bus.act_rank_update;

    // Slot occupancy and lowest-idle-slot selection.
    // A slot at 1 is still busy, so an expiring slot is never reused in the same cycle.
    always_comb begin
        for (int r = 0; r < RANK_SLAB; r++) begin
            busy[r]     = 4'd0;
            load_sel[r] = 4'd0;
            for (int s = 0; s < 4; s++) begin
                busy[r][s] = |slot_q[r][s];
            end
            faw_ok_c[r] = ~&busy[r];
            if (act[r] && faw_ok_c[r]) begin
                // busy + 1 turns the lowest zero bit into the only new one.
                load_sel[r] = ~busy[r] & (busy[r] + 4'd1);
            end
        end
    end

    // Violation detect: multi-hot strobe, strobe during tRRD, or strobe on a full rank.
    always_comb begin
        rrd_ok_c  = (rrd_q == '0);
        multi_hot = |(act & (act - RANK_SLAB'(1)));
        viol_now  = multi_hot | ((|act) & ~rrd_ok_c) | (|(act & ~faw_ok_c));
    end

    // Window slots: a load wins over a decrement; an idle slot holds at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < RANK_SLAB; r++) begin
                for (int s = 0; s < 4; s++) begin
                    slot_q[r][s] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < RANK_SLAB; r++) begin
                for (int s = 0; s < 4; s++) begin
                    if (load_sel[r][s]) begin
                        slot_q[r][s] <= FAW_LD;
                    end else if (busy[r][s]) begin
                        slot_q[r][s] <= slot_q[r][s] - 1'b1;
                    end
                end
            end
        end
    end

    // Global spacing counter. It reloads on any strobe, including a dropped one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_q <= '0;
        end else if (|act) begin
            rrd_q <= RRD_LD;
        end else if (rrd_q != '0) begin
            rrd_q <= rrd_q - 1'b1;
        end
    end

    // Sticky violation flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_q <= 1'b0;
        end else if (viol_now) begin
            viol_q <= 1'b1;
        end
    end

    assign bus.faw_ok   = faw_ok_c;
    assign bus.rrd_ok   = rrd_ok_c;
    assign bus.act_viol = viol_q;

`ifdef DDR4_MC_ACT_FAW_STATS_EN
    logic [15:0] stall_q;

    // Count cycles with any rank blocked by tFAW; saturate at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else if (!(&faw_ok_c) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.faw_stall_cnt = stall_q;
`else
    assign bus.faw_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ddr4_mc_act_faw.sv
// Randomized and directed bench for ddr4_mc_act_faw against a
// time-stamp reference model.
// The model treats an accepted activate at t as occupying its rank during cycles t+1..t+TFAW-1.
// The model treats a strobe at t as blocking tRRD during cycles t+1..t+TRRD-1.
module tb_ddr4_mc_act_faw;
    localparam int NR   = 4;
    localparam int TFAW = 16;
    localparam int TRRD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    ddr4_mc_act_faw_if #(.RANK_SLAB(NR)) bus ();

    ddr4_mc_act_faw #(.RANK_SLAB(NR), .TFAW(TFAW), .TRRD(TRRD), .CNTW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int m_cyc;
    int m_acc [NR][$];
    int m_last;
    bit m_viol;
    int m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, m_cyc, obs, exp);
        end
    endtask

    function automatic bit m_faw_ok(input int r);
        int cnt = 0;
        foreach (m_acc[r][i]) begin
            if (m_acc[r][i] >= m_cyc - TFAW + 1 && m_acc[r][i] <= m_cyc - 1) cnt++;
        end
        return cnt < 4;
    endfunction

    function automatic logic [NR-1:0] m_faw_vec();
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = m_faw_ok(r);
        return v;
    endfunction

    function automatic bit m_rrd_ok();
        return (m_cyc - m_last) >= TRRD;
    endfunction

    function automatic int m_stall_exp();
`ifdef DDR4_MC_ACT_FAW_STATS_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    task automatic m_reset();
        m_cyc   = 0;
        m_last  = -1000;
        m_viol  = 0;
        m_stall = 0;
        for (int r = 0; r < NR; r++) m_acc[r].delete();
    endtask

    task automatic m_step(input logic [NR-1:0] a);
        logic [NR-1:0] ok;
        int            n;
        ok = m_faw_vec();
        n  = $countones(a);
        if (n > 0) begin
            if (!m_rrd_ok()) m_viol = 1;
            if (n > 1) m_viol = 1;
            for (int r = 0; r < NR; r++) begin
                if (a[r]) begin
                    if (ok[r]) m_acc[r].push_back(m_cyc);
                    else m_viol = 1;
                end
            end
            m_last = m_cyc;
        end
        if (!(&ok) && m_stall < 65535) m_stall++;
        m_cyc++;
    endtask

    task automatic check_outputs();
        chk("faw_ok", 32'(bus.faw_ok), 32'(m_faw_vec()));
        chk("rrd_ok", 32'(bus.rrd_ok), 32'(m_rrd_ok()));
        chk("act_viol", 32'(bus.act_viol), 32'(m_viol));
        chk("stall_cnt", 32'(bus.faw_stall_cnt), 32'(m_stall_exp()));
    endtask

    // One cycle: drive shortly after posedge, check at negedge, then advance the model.
    task automatic run_cycle(input logic [NR-1:0] a);
        bus.act_rank_update = a;
        @(negedge clk);
        check_outputs();
        m_step(a);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear before any edge.
    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        bus.act_rank_update = '0;
        #1;
        chk("rst_faw_ok", 32'(bus.faw_ok), 32'hF);
        chk("rst_rrd_ok", 32'(bus.rrd_ok), 32'd1);
        chk("rst_viol", 32'(bus.act_viol), 32'd0);
        chk("rst_stall", 32'(bus.faw_stall_cnt), 32'd0);
        m_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [NR-1:0] a;
        int            p;
        bus.act_rank_update = '0;
        m_reset();
        @(posedge clk);
        #1;
        pulse_reset();

        // Rank 0 strobed at 10, 14, 18 and 22: legal, tFAW low on 23..25.
        for (int c = 0; c < 40; c++) begin
            a = '0;
            if (c == 10 || c == 14 || c == 18 || c == 22) a[0] = 1'b1;
            run_cycle(a);
            if (c == 24) chk("s1_faw0_low", 32'(bus.faw_ok[0]), 32'd0);
            if (c == 26) chk("s1_viol", 32'(bus.act_viol), 32'd0);
        end
        pulse_reset();

        // Add rank 1 strobes at 12, 16 and 20; these violate tRRD.
        for (int c = 0; c < 40; c++) begin
            a = '0;
            if (c == 10 || c == 14 || c == 18 || c == 22) a[0] = 1'b1;
            if (c == 12 || c == 16 || c == 20) a[1] = 1'b1;
            run_cycle(a);
        end
        chk("s2_viol", 32'(bus.act_viol), 32'd1);
        pulse_reset();

        // Rank 2: the fifth strobe at 14 is dropped; faw_ok[2] rises at 16.
        for (int c = 0; c < 30; c++) begin
            a = '0;
            if (c == 0 || c == 4 || c == 8 || c == 12 || c == 14) a[2] = 1'b1;
            run_cycle(a);
        end
        pulse_reset();

        // Multi-hot strobe at cycle 5.
        for (int c = 0; c < 25; c++) begin
            a = (c == 5) ? 4'b0011 : 4'b0000;
            run_cycle(a);
        end
        pulse_reset();

        // Reset mid-window at cycle 20 of the first pattern.
        for (int c = 0; c < 21; c++) begin
            a = '0;
            if (c == 10 || c == 14 || c == 18) a[0] = 1'b1;
            run_cycle(a);
        end
        pulse_reset();

        // Random traffic. Resets are periodic so the sticky flag does not mask later cycles.
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 249) pulse_reset();
            p = $urandom_range(0, 99);
            a = '0;
            if (p < 45) a = '0;
            else if (p < 96) a[$urandom_range(0, NR - 1)] = 1'b1;
            else a = NR'($urandom);
            run_cycle(a);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
